// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// One shift-and-add-3 step per clock; a conversion takes WIDTH SHIFT cycles
// followed by a one-cycle DONE state in which done pulses and bcd is fresh.
//
// Handshake: a conversion is requested by start (sampled on a rising clk edge)
// and is accepted only when busy is low (IDLE or DONE).  Requests while busy
// are dropped, never queued.  done is high for exactly the one cycle in which
// bcd first shows the new result; bcd is otherwise held.
//
// Optional feature macro: BIN2BCD_AUTO_START_EN
//   When defined, a last_bin register remembers the last accepted input and any
//   difference between bin and last_bin raises an internal start request
//   (ORed with the start port), so a changing counter re-converts by itself.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam longint unsigned MAX_BIN   = (64'd1 << WIDTH) - 64'd1;
    localparam longint unsigned DEC_RANGE = 64'd10 ** DIGITS;

    // Refuse to elaborate when DIGITS cannot represent the largest input.
    if (DEC_RANGE <= MAX_BIN) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    scratch_q, scratch_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bcd_q, bcd_d;

    logic [BW-1:0]    adj;
    logic [BW-1:0]    step_scratch;
    logic [WIDTH-1:0] step_shift;
    logic             start_eff;

`ifdef BIN2BCD_AUTO_START_EN
    logic [WIDTH-1:0] last_bin_q, last_bin_d;

    // Internal request whenever the input differs from the last accepted value.
    always_comb begin
        start_eff = start | (bin != last_bin_q);
    end

    // Remember the value of each accepted conversion.
    always_comb begin
        last_bin_d = last_bin_q;
        if (start_eff && (state_q != S_SHIFT)) begin
            last_bin_d = bin;
        end
    end

    // last_bin register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_bin_q <= '0;
        end else begin
            last_bin_q <= last_bin_d;
        end
    end
`else
    // Conversions are requested only through the start port.
    always_comb begin
        start_eff = start;
    end
`endif

    // Add-3 correction: every scratch digit >= 5 gets +3 (4-bit, no carry out).
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        step_scratch = (adj << 1) | BW'(shift_q[WIDTH-1]);
        step_shift   = shift_q << 1;
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                if (start_eff) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
                    state_d   = S_SHIFT;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_SHIFT: begin
                busy      = 1'b1;
                scratch_d = step_scratch;
                shift_d   = step_shift;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = step_scratch;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
        end
    end

    assign bcd = bcd_q;

endmodule
